n_body_verlet_stage: RTL

Synthesizable fixed-point Verlet position-update stage sitting directly downstream of the 4-body systolic force array. Consumes per-body accumulated accelerations (un-scaled by G), one body per handshake in index order. Holds the q(t) and q(t-dt) banks for all bodies and emits updated positions q(t+dt) for the next array pass. Implements the Verlet update with G·dt² folded into one fixed-point constant.

---
 rtl/n_body_verlet_stage.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/n_body_verlet_stage.sv
// Fixed-point Verlet position update: q(t+dt) = 2q(t) - q(t-dt) + G*dt^2*a.
// Owns the q(t) / q(t-dt) banks; one body per handshake, in index order.
module n_body_verlet_stage #(
   parameter int N_BODIES = 4,
   parameter int W = 32,
   parameter int FRAC = 16,
   parameter logic signed [W-1:0] G_DT2 = 32'sd65536,
   localparam int IW = $clog2(N_BODIES)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          init_en,
   input  logic [IW-1:0] init_idx,
   input  logic [W-1:0]  init_q,
   input  logic [W-1:0]  init_q_old,
   input  logic          start,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [W-1:0]  a_data,
   output logic          q_valid,
   input  logic          q_ready,
   output logic [W-1:0]  q_data,
   output logic [IW-1:0] q_idx,
   output logic          busy,
   output logic          step_done
);

   localparam int CW = IW + 1;
   localparam int PW = 2 * W;
   localparam int SW = PW + 2;
   localparam logic [CW-1:0] NB = CW'(N_BODIES);
   localparam logic [CW-1:0] NB_M1 = CW'(N_BODIES - 1);
   localparam logic [IW-1:0] LAST = IW'(N_BODIES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t state_q, state_d;

   logic [CW-1:0] in_cnt;
   logic [CW-1:0] out_cnt;
   logic [W-1:0]  q_t   [N_BODIES];
   logic [W-1:0]  q_old [N_BODIES];

   logic                 s1_valid;
   logic [IW-1:0]        s1_idx;
   logic signed [PW-1:0] s1_prod;

   logic                 adv;
   logic                 a_hs;
   logic                 q_hs;
   logic                 last_hs;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] sh;
   logic [W-1:0]         rd_t;
   logic [W-1:0]         rd_o;
   logic signed [SW-1:0] t_ext;
   logic signed [SW-1:0] o_ext;
   logic signed [SW-1:0] d_ext;
   logic signed [SW-1:0] sum;
   logic [SW-W:0]        top;
   logic [W-1:0]         sat;

   assign adv     = !q_valid || q_ready;
   assign a_ready = (state_q == RUN) && (in_cnt < NB) && adv;
   assign a_hs    = a_valid && a_ready;
   assign q_hs    = q_valid && q_ready;
   assign last_hs = q_hs && (q_idx == LAST) && (out_cnt == NB_M1);
   assign busy    = (state_q != IDLE);

   assign prod = $signed({{W{a_data[W-1]}}, a_data})
               * $signed({{W{G_DT2[W-1]}}, G_DT2});

   // Sum is kept wide enough that no operand combination can wrap.
   always_comb begin
      rd_t  = q_t[s1_idx];
      rd_o  = q_old[s1_idx];
      sh    = s1_prod >>> FRAC;
      t_ext = {{(SW-W){rd_t[W-1]}}, rd_t};
      o_ext = {{(SW-W){rd_o[W-1]}}, rd_o};
      d_ext = {{(SW-PW){sh[PW-1]}}, sh};
      sum   = (t_ext <<< 1) - o_ext + d_ext;
      top   = sum[SW-1:W-1];
      if (top == '0 || top == '1)
         sat = sum[W-1:0];
      else if (sum[SW-1])
         sat = {1'b1, {(W-1){1'b0}}};
      else
         sat = {1'b0, {(W-1){1'b1}}};
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (a_hs && in_cnt == NB_M1) state_d = DRAIN;
         DRAIN:   if (last_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         in_cnt    <= '0;
         out_cnt   <= '0;
         s1_valid  <= 1'b0;
         s1_idx    <= '0;
         s1_prod   <= '0;
         q_valid   <= 1'b0;
         q_data    <= '0;
         q_idx     <= '0;
         step_done <= 1'b0;
         for (int k = 0; k < N_BODIES; k++) begin
            q_t[k]   <= '0;
            q_old[k] <= '0;
         end
      end else begin
         state_q   <= state_d;
         step_done <= last_hs;
         if (state_q == IDLE) begin
            if (start) begin
               in_cnt  <= '0;
               out_cnt <= '0;
            end
            if (init_en) begin
               q_t[init_idx]   <= init_q;
               q_old[init_idx] <= init_q_old;
            end
         end else begin
            if (a_hs) in_cnt <= in_cnt + 1'b1;
            if (q_hs) out_cnt <= out_cnt + 1'b1;
         end
         if (adv) begin
            s1_valid <= a_hs;
            if (a_hs) begin
               s1_idx  <= in_cnt[IW-1:0];
               s1_prod <= prod;
            end
            q_valid <= s1_valid;
            if (s1_valid) begin
               q_data        <= sat;
               q_idx         <= s1_idx;
               q_t[s1_idx]   <= sat;
               q_old[s1_idx] <= rd_t;
            end
         end
      end
   end

endmodule
